dec3x8_hs: RTL and testbench

- Handshaked, buffered 3-to-8 binary-to-one-hot decoder. It is the inverse of the team's 8-to-3 priority encoder.
- It accepts a 3-bit index plus an enable bit over a valid/ready interface and decodes it into an 8-bit one-hot word.
- Decoded words are held in a small FIFO and presented on a valid/ready output, so upstream and downstream can stall independently. Typical use is driving grant/select lines from an encoded arbiter result.

---
 rtl/dec3x8_hs.sv | 99 +++++++++
 tb/tb_dec3x8_hs.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dec3x8_hs.sv
// dec3x8_hs: handshaked, buffered 3-to-8 binary-to-one-hot decoder.
// Codes accepted on the valid/ready input are decoded on entry and stored,
// together with the original index, in a small FIFO whose head drives the
// valid/ready output. There is no combinational path from input to output.
module dec3x8_hs #(
  parameter int DEPTH   = 2,     // FIFO entries, power of two in 2..8
  parameter bit ACT_LOW = 1'b0   // 1: whole output word inverted
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_code,
  input  logic                     in_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_onehot,
  output logic [2:0]               out_code,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int             AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             LW   = $clog2(DEPTH) + 1;
  localparam logic [7:0]     IDLE = ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [LW-1:0]  FULL = LW'(DEPTH);

  logic [7:0]    word_mem [DEPTH];
  logic [2:0]    code_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [7:0]    dec_word;
  logic          push;
  logic          pop;

  // Ready/valid depend on stored occupancy only, so neither side sees a
  // combinational path through the other.
  assign in_ready  = (level_q != FULL);
  assign out_valid = (level_q != '0);
  assign push      = in_valid  && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = level_q;

  // Decode the incoming index; a disabled entry decodes to the idle word.
  always_comb begin
    // NOTE: default assignment first so no path leaves dec_word unassigned,
    // which would otherwise infer a latch.
    dec_word = 8'h00;
    if (in_en) begin
      dec_word = 8'h01 << in_code;
    end
    dec_word = dec_word ^ IDLE;
  end

  // Storage array written on accept; pointers alone define which entries
  // are live, so the contents never need clearing.
  // NOTE: the memory has no reset on purpose -- resetting an array forces it
  // into flops and adds nothing, since empty entries are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr] <= dec_word;
      code_mem[wr_ptr] <= in_code;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Head entry drives the outputs; an empty FIFO shows the idle word and 0.
  always_comb begin
    out_onehot = IDLE;
    out_code   = 3'd0;
    if (out_valid) begin
      out_onehot = word_mem[rd_ptr];
      out_code   = code_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_dec3x8_hs.sv
// Directed testbench for dec3x8_hs. Three instances share clock and reset:
//   a: DEPTH=2, ACT_LOW=0   b: DEPTH=2, ACT_LOW=1   c: DEPTH=4, ACT_LOW=0
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. they reflect the state left by that edge.
module tb_dec3x8_hs;

  logic clk;
  logic rst_n;

  logic       a_in_valid, a_in_ready, a_in_en, a_out_valid, a_out_ready;
  logic [2:0] a_in_code, a_out_code;
  logic [7:0] a_out_onehot;
  logic [1:0] a_level;

  logic       b_in_valid, b_in_ready, b_in_en, b_out_valid, b_out_ready;
  logic [2:0] b_in_code, b_out_code;
  logic [7:0] b_out_onehot;
  logic [1:0] b_level;

  logic       c_in_valid, c_in_ready, c_in_en, c_out_valid, c_out_ready;
  logic [2:0] c_in_code, c_out_code;
  logic [7:0] c_out_onehot;
  logic [2:0] c_level;

  int tests_run = 0;
  int tests_failed = 0;

  dec3x8_hs #(.DEPTH(2), .ACT_LOW(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_code(a_in_code), .in_en(a_in_en),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_onehot(a_out_onehot),
    .out_code(a_out_code), .level(a_level)
  );

  dec3x8_hs #(.DEPTH(2), .ACT_LOW(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_code(b_in_code), .in_en(b_in_en),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_onehot(b_out_onehot),
    .out_code(b_out_code), .level(b_level)
  );

  dec3x8_hs #(.DEPTH(4), .ACT_LOW(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_code(c_in_code), .in_en(c_in_en),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_onehot(c_out_onehot),
    .out_code(c_out_code), .level(c_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the full output view of instance a.
  task automatic check_a(input string tag, input logic v, input logic [7:0] oh,
                         input logic [2:0] code, input logic [1:0] lvl, input logic rdy);
    check({tag, ".a.out_valid"},  32'(a_out_valid),  32'(v));
    check({tag, ".a.out_onehot"}, 32'(a_out_onehot), 32'(oh));
    check({tag, ".a.out_code"},   32'(a_out_code),   32'(code));
    check({tag, ".a.level"},      32'(a_level),      32'(lvl));
    check({tag, ".a.in_ready"},   32'(a_in_ready),   32'(rdy));
  endtask

  task automatic check_c(input string tag, input logic v, input logic [7:0] oh,
                         input logic [2:0] code, input logic [2:0] lvl, input logic rdy);
    check({tag, ".c.out_valid"},  32'(c_out_valid),  32'(v));
    check({tag, ".c.out_onehot"}, 32'(c_out_onehot), 32'(oh));
    check({tag, ".c.out_code"},   32'(c_out_code),   32'(code));
    check({tag, ".c.level"},      32'(c_level),      32'(lvl));
    check({tag, ".c.in_ready"},   32'(c_in_ready),   32'(rdy));
  endtask

  initial begin
    a_in_valid = 0; a_in_code = 0; a_in_en = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_code = 0; b_in_en = 0; b_out_ready = 0;
    c_in_valid = 0; c_in_code = 0; c_in_en = 0; c_out_ready = 0;

    // ---- Reset with no clock edge yet (first rising edge is at t=5) ----
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_a("reset", 1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
    check("reset.b.out_onehot", 32'(b_out_onehot), 32'h0000_00FF);
    check("reset.b.out_valid",  32'(b_out_valid),  32'd0);
    check_c("reset", 1'b0, 8'h00, 3'd0, 3'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check_a("post_reset", 1'b0, 8'h00, 3'd0, 2'd0, 1'b1);

    // ---- Sweep 0..7, out_ready=1: each word appears 1 cycle after accept ----
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_en     = 1'b1;
    a_in_code   = 3'd0;
    check("sweep.no_early_out", 32'(a_out_valid), 32'd0);
    tick();
    check_a("sweep0", 1'b1, 8'h01, 3'd0, 2'd1, 1'b1);
    a_in_code = 3'd1; tick(); check_a("sweep1", 1'b1, 8'h02, 3'd1, 2'd1, 1'b1);
    a_in_code = 3'd2; tick(); check_a("sweep2", 1'b1, 8'h04, 3'd2, 2'd1, 1'b1);
    a_in_code = 3'd3; tick(); check_a("sweep3", 1'b1, 8'h08, 3'd3, 2'd1, 1'b1);
    a_in_code = 3'd4; tick(); check_a("sweep4", 1'b1, 8'h10, 3'd4, 2'd1, 1'b1);
    a_in_code = 3'd5; tick(); check_a("sweep5", 1'b1, 8'h20, 3'd5, 2'd1, 1'b1);
    a_in_code = 3'd6; tick(); check_a("sweep6", 1'b1, 8'h40, 3'd6, 2'd1, 1'b1);
    a_in_code = 3'd7; tick(); check_a("sweep7", 1'b1, 8'h80, 3'd7, 2'd1, 1'b1);
    a_in_valid = 1'b0;
    tick();
    check_a("sweep_drain", 1'b0, 8'h00, 3'd0, 2'd0, 1'b1);

    // ---- Enable-off entry on a (ACT_LOW=0) and b (ACT_LOW=1) ----
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_code = 3'd5; a_in_en = 1'b0;
    b_in_valid = 1'b1; b_in_code = 3'd5; b_in_en = 1'b0;
    tick();
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    check_a("en_off", 1'b1, 8'h00, 3'd5, 2'd1, 1'b1);
    check("en_off.b.out_onehot", 32'(b_out_onehot), 32'h0000_00FF);
    check("en_off.b.out_code",   32'(b_out_code),   32'd5);
    check("en_off.b.out_valid",  32'(b_out_valid),  32'd1);
    // Enabled code on b: only bit 2 driven low.
    b_in_valid = 1'b1; b_in_code = 3'd2; b_in_en = 1'b1; b_out_ready = 1'b1;
    tick();
    b_in_valid = 1'b0;
    check("act_low.b.out_onehot", 32'(b_out_onehot), 32'h0000_00FB);
    check("act_low.b.out_code",   32'(b_out_code),   32'd2);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    check_a("en_off_drain", 1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
    check("act_low_drain.b.out_onehot", 32'(b_out_onehot), 32'h0000_00FF);
    check("act_low_drain.b.level",      32'(b_level),      32'd0);

    // ---- Backpressure, DEPTH=2 ----
    a_in_en = 1'b1;
    a_in_valid = 1'b1; a_in_code = 3'd3; tick();
    a_in_code = 3'd6; tick();
    check_a("bp_full", 1'b1, 8'h08, 3'd3, 2'd2, 1'b0);
    a_in_code = 3'd1; tick();
    check_a("bp_blocked1", 1'b1, 8'h08, 3'd3, 2'd2, 1'b0);
    tick();
    check_a("bp_blocked2", 1'b1, 8'h08, 3'd3, 2'd2, 1'b0);
    a_out_ready = 1'b1;
    tick();  // pop 3; code 1 not taken since FIFO was full at this edge
    check_a("bp_pop3", 1'b1, 8'h40, 3'd6, 2'd1, 1'b1);
    tick();  // pop 6 and accept code 1
    a_in_valid = 1'b0;
    check_a("bp_pop6", 1'b1, 8'h02, 3'd1, 2'd1, 1'b1);
    tick();
    check_a("bp_pop1", 1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
    tick();
    check_a("bp_no_dup", 1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
    a_out_ready = 1'b0;

    // ---- DEPTH=4: fill to 3, push+pop, full, wrap ----
    c_in_en = 1'b1;
    c_in_valid = 1'b1; c_in_code = 3'd7; tick();
    c_in_code = 3'd4; tick();
    c_in_code = 3'd5; tick();
    check_c("d4_lvl3", 1'b1, 8'h80, 3'd7, 3'd3, 1'b1);
    c_in_code = 3'd2; c_out_ready = 1'b1; tick();
    check_c("d4_pushpop", 1'b1, 8'h10, 3'd4, 3'd3, 1'b1);
    c_out_ready = 1'b0;
    c_in_code = 3'd6; tick();
    check_c("d4_full", 1'b1, 8'h10, 3'd4, 3'd4, 1'b0);
    c_in_code = 3'd3; tick();
    check_c("d4_blocked1", 1'b1, 8'h10, 3'd4, 3'd4, 1'b0);
    tick();
    check_c("d4_blocked2", 1'b1, 8'h10, 3'd4, 3'd4, 1'b0);
    c_out_ready = 1'b1;
    tick();  // pop 4 only
    check_c("d4_pop4", 1'b1, 8'h20, 3'd5, 3'd3, 1'b1);
    tick();  // pop 5, accept 3
    c_in_valid = 1'b0;
    check_c("d4_pop5", 1'b1, 8'h04, 3'd2, 3'd3, 1'b1);
    tick();
    check_c("d4_pop2", 1'b1, 8'h40, 3'd6, 3'd2, 1'b1);
    tick();
    check_c("d4_pop6", 1'b1, 8'h08, 3'd3, 3'd1, 1'b1);
    tick();
    check_c("d4_empty", 1'b0, 8'h00, 3'd0, 3'd0, 1'b1);
    c_out_ready = 1'b0;

    // ---- Reset mid-stream with level=2 ----
    a_in_valid = 1'b1; a_in_code = 3'd1; tick();
    a_in_code = 3'd2; tick();
    a_in_valid = 1'b0;
    check_a("pre_rst", 1'b1, 8'h02, 3'd1, 2'd2, 1'b0);
    rst_n = 1'b0;
    #1;
    check_a("mid_rst_async", 1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
    #3 rst_n = 1'b1;
    a_out_ready = 1'b1;
    tick();
    check_a("post_rst1", 1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
    tick();
    check_a("post_rst2", 1'b0, 8'h00, 3'd0, 2'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
